disp_scan_4dig: RTL

- Four-digit time-multiplexed display scanner that sits directly upstream of the 7-segment hex decoder.
- Holds four 4-bit digit values written by the host logic and presents one digit at a time on D, C, B, A for the decoder.
- Drives active-low common digit enables in step with the presented digit.
- Inserts a blanking gap between digits to prevent ghosting. Double-buffers digit values so a display update is always frame-coherent.

---
 rtl/disp_scan_4dig.sv | 120 ++++++++++++
 1 files changed

// File: rtl/disp_scan_4dig.sv
// rtl/disp_scan_4dig.sv - four-digit time-multiplexed scanner with blanking gap and frame-coherent double buffer
// Optional: DISP_SCAN_LEADING_ZERO_BLANK_EN suppresses leading-zero digits 3..1.
module disp_scan_4dig #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic       D,
    output logic       C,
    output logic       B,
    output logic       A,
    output logic [3:0] dig_n,
    output logic       frame_tick
);

    generate
        if (SCAN_DIV <= BLANK_CYC || BLANK_CYC == 0 ||
            longint'(SCAN_DIV) >= (longint'(1) << CNT_W)) begin : g_bad_params
            $error("disp_scan_4dig: illegal SCAN_DIV/BLANK_CYC/CNT_W combination");
        end
    endgenerate

    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0][3:0]  shadow_q, shadow_d;
    logic [3:0][3:0]  active_q, active_d;
    logic             dirty_q, dirty_d;
    logic [3:0]       dig_q, dig_d;
    logic [3:0]       dcba_q, dcba_d;
    logic             tick_q, tick_d;
    logic             lz_blank;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        shadow_d = shadow_q;
        active_d = active_q;
        dirty_d  = dirty_q;
        tick_d   = 1'b0;

        if (state_q == ST_BLANK) begin
            if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
        end else if (cnt_q == SLOT_LAST) begin
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
            state_d = ST_BLANK;
            if (idx_q == 2'd3) begin
                tick_d = 1'b1;
                // Copy uses the pre-write shadow; a colliding write re-arms dirty below.
                if (dirty_q) begin
                    active_d = shadow_q;
                    dirty_d  = 1'b0;
                end
            end
        end

        if (wr_en) begin
            shadow_d[wr_addr] = wr_data;
            dirty_d           = 1'b1;
        end
    end

    // Outputs are registered from next-state values so they line up with state.
    always_comb begin
        lz_blank = 1'b0;
`ifdef DISP_SCAN_LEADING_ZERO_BLANK_EN
        case (idx_d)
            2'd3:    lz_blank = (active_d[3] == 4'd0);
            2'd2:    lz_blank = (active_d[3] == 4'd0) && (active_d[2] == 4'd0);
            2'd1:    lz_blank = (active_d[3] == 4'd0) && (active_d[2] == 4'd0) &&
                                (active_d[1] == 4'd0);
            default: lz_blank = 1'b0;
        endcase
`endif
        dig_d = 4'hF;
        if (state_d == ST_SHOW && !lz_blank) dig_d[idx_d] = 1'b0;
        dcba_d = active_d[idx_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_BLANK;
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            shadow_q <= '0;
            active_q <= '0;
            dirty_q  <= 1'b0;
            dig_q    <= 4'hF;
            dcba_q   <= 4'd0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            dirty_q  <= dirty_d;
            dig_q    <= dig_d;
            dcba_q   <= dcba_d;
            tick_q   <= tick_d;
        end
    end

    assign {D, C, B, A} = dcba_q;
    assign dig_n        = dig_q;
    assign frame_tick   = tick_q;

endmodule
